// File: rtl/u_wb_buf.sv
// u_wb_buf: writeback delay buffer between the execute result mux and the
// regfile write port. DEPTH-stage shift pipe with stall hold, flush gating,
// x0 suppression, occupancy count and multi-port youngest-wins forwarding.
module u_wb_buf #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NRP    = 2,
  parameter int unsigned FWD_IN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_we,
  input  logic [AW-1:0]                in_a,
  input  logic [XLEN-1:0]              in_d,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         rf_rd_e,
  output logic [AW-1:0]                rf_rd_a,
  output logic [XLEN-1:0]              rf_rd_i,
  input  logic [NRP*AW-1:0]            fwd_a,
  output logic [NRP-1:0]               fwd_hit,
  output logic [NRP*XLEN-1:0]          fwd_d,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         busy
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic            v_q [DEPTH];
  logic [AW-1:0]   a_q [DEPTH];
  logic [XLEN-1:0] d_q [DEPTH];
  logic [CW-1:0]   cnt_q;

  logic in_ok;  // request is a real write, independent of stall
  logic acc;    // request actually enters stage 0 this edge

  assign in_ok = in_we & ~flush & (in_a != '0);
  assign acc   = in_ok & ~stall;

  // Shift pipeline and occupancy counter; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        d_q[k] <= '0;
      end
      cnt_q <= '0;
    end else if (!stall) begin
      v_q[0] <= acc;
      a_q[0] <= acc ? in_a : '0;
      d_q[0] <= acc ? in_d : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        d_q[k] <= d_q[k-1];
      end
      cnt_q <= cnt_q + CW'(acc) - CW'(v_q[DEPTH-1]);
    end
  end

  // Oldest stage drives the regfile; enable is masked while stalled so a
  // held entry is written only on the cycle it actually leaves.
  assign rf_rd_e = v_q[DEPTH-1] & ~stall;
  assign rf_rd_a = a_q[DEPTH-1];
  assign rf_rd_i = d_q[DEPTH-1];

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

  // Forwarding lookup: scan oldest to youngest so the youngest match is the
  // last assignment and wins. x0 never matches since valid entries are never x0.
  always_comb begin
    logic [AW-1:0] qa;
    fwd_hit = '0;
    fwd_d   = '0;
    qa      = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      qa = fwd_a[p*AW +: AW];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (v_q[DEPTH-1-k] && (a_q[DEPTH-1-k] == qa)) begin
          fwd_hit[p]               = 1'b1;
          fwd_d[p*XLEN +: XLEN]    = d_q[DEPTH-1-k];
        end
      end
      if ((FWD_IN != 0) && in_ok && (in_a == qa)) begin
        fwd_hit[p]            = 1'b1;
        fwd_d[p*XLEN +: XLEN] = in_d;
      end
    end
    // in_* is not reset, so mask the lookup while reset is asserted.
    if (rst) begin
      fwd_hit = '0;
      fwd_d   = '0;
    end
  end

endmodule

// File: tb/tb_u_wb_buf.sv
// tb_u_wb_buf: directed test of u_wb_buf (DEPTH=3, NRP=2, FWD_IN=1).
// Expected regfile writes go into a scoreboard queue; a monitor pops them.
module tb_u_wb_buf;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NRP  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_we;
  logic [AW-1:0]        in_a;
  logic [XLEN-1:0]      in_d;
  logic                 flush;
  logic                 stall;
  logic                 rf_rd_e;
  logic [AW-1:0]        rf_rd_a;
  logic [XLEN-1:0]      rf_rd_i;
  logic [NRP*AW-1:0]    fwd_a;
  logic [NRP-1:0]       fwd_hit;
  logic [NRP*XLEN-1:0]  fwd_d;
  logic [1:0]           cnt;
  logic                 busy;

  u_wb_buf #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NRP(NRP), .FWD_IN(1)) dut (
    .clk(clk), .rst(rst), .in_we(in_we), .in_a(in_a), .in_d(in_d),
    .flush(flush), .stall(stall), .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a),
    .rf_rd_i(rf_rd_i), .fwd_a(fwd_a), .fwd_hit(fwd_hit), .fwd_d(fwd_d),
    .cnt(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                       input logic fl, input logic st);
    in_we = we; in_a = a; in_d = d; flush = fl; stall = st;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic expect_wr(input int c, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t e;
    e.cyc = c; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: every regfile write must match the next scoreboard entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_rd_e === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rf_unexpected: write a=%0d d=%0h at cycle %0d, expected no write",
                   rf_rd_a, rf_rd_i, cyc);
        end else begin
          e = sb.pop_front();
          chk("rf_cycle", 64'(cyc), 64'(e.cyc));
          chk("rf_addr", 64'(rf_rd_a), 64'(e.a));
          chk("rf_data", 64'(rf_rd_i), 64'(e.d));
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    fwd_a = '0;
    idle();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset initial state
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Reset mid-flight: three entries in flight, then async reset mid-cycle
    drive(1'b1, 5'd21, 32'h2100, 1'b0, 1'b0); step();
    drive(1'b1, 5'd22, 32'h2200, 1'b0, 1'b0); step();
    drive(1'b1, 5'd23, 32'h2300, 1'b0, 1'b0); step();
    drive(1'b1, 5'd5,  32'h5555, 1'b0, 1'b0);
    fwd_a = {5'd22, 5'd5};
    #1;
    chk("pre_rst_cnt", 64'(cnt), 64'd3);
    chk("pre_rst_hit", 64'(fwd_hit), 64'b11);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rf_e", 64'(rf_rd_e), 64'd0);
    chk("rst_rf_a", 64'(rf_rd_a), 64'd0);
    chk("rst_rf_d", 64'(rf_rd_i), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_d", 64'(fwd_d), 64'd0);
    chk("rst_cnt_async", 64'(cnt), 64'd0);
    chk("rst_busy_async", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    idle();
    fwd_a = '0;
    repeat (5) step();
    chk("post_rst_cnt", 64'(cnt), 64'd0);

    // Latency: single write, regfile sees it DEPTH cycles later
    c = cyc;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
    expect_wr(c + 3, 5'd5, 32'h1234);
    #1 chk("lat_cnt0", 64'(cnt), 64'd0);
    step(); idle();
    chk("lat_cnt1", 64'(cnt), 64'd1);
    step();
    chk("lat_cnt2", 64'(cnt), 64'd1);
    step();
    chk("lat_cnt3", 64'(cnt), 64'd1);
    chk("lat_busy", 64'(busy), 64'd1);
    step();
    chk("lat_cnt4", 64'(cnt), 64'd0);
    chk("lat_busy4", 64'(busy), 64'd0);
    step();

    // Stream with an x0 write in the middle
    c = cyc;
    drive(1'b1, 5'd1, 32'h11, 1'b0, 1'b0); expect_wr(c + 3, 5'd1, 32'h11); step();
    drive(1'b1, 5'd2, 32'h22, 1'b0, 1'b0); expect_wr(c + 4, 5'd2, 32'h22); step();
    drive(1'b1, 5'd0, 32'h33, 1'b0, 1'b0);
    chk("str_cnt2", 64'(cnt), 64'd2); step();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 1'b0); expect_wr(c + 6, 5'd4, 32'h44);
    chk("str_cnt3", 64'(cnt), 64'd2); step();
    idle();
    chk("str_cnt4", 64'(cnt), 64'd2); step();
    chk("str_cnt5", 64'(cnt), 64'd1); step();
    chk("str_cnt6", 64'(cnt), 64'd1); step();
    chk("str_cnt7", 64'(cnt), 64'd0);
    step();

    // Stall while entry is in stage 1; in_we during stall is ignored
    c = cyc;
    drive(1'b1, 5'd7, 32'h77, 1'b0, 1'b0); expect_wr(c + 5, 5'd7, 32'h77); step();
    idle(); step();
    drive(1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
    chk("stl_cnt2", 64'(cnt), 64'd1); step();
    drive(1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
    chk("stl_cnt3", 64'(cnt), 64'd1); step();
    idle();
    chk("stl_cnt4", 64'(cnt), 64'd1);
    repeat (3) step();
    chk("stl_cnt_end", 64'(cnt), 64'd0);

    // Stall while entry sits in the last stage: write exactly once on exit
    c = cyc;
    drive(1'b1, 5'd12, 32'hC0DE, 1'b0, 1'b0); expect_wr(c + 4, 5'd12, 32'hC0DE); step();
    idle(); step(); step();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    #1 chk("stl2_rf_e", 64'(rf_rd_e), 64'd0);
    chk("stl2_rf_a", 64'(rf_rd_a), 64'd12);
    step();
    idle();
    repeat (3) step();

    // Flush: request is dropped and never forwarded
    drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
    fwd_a = {5'd0, 5'd9};
    #1 chk("fl_hit_in", 64'(fwd_hit), 64'd0);
    step();
    idle();
    chk("fl_hit_s0", 64'(fwd_hit), 64'd0);
    chk("fl_cnt", 64'(cnt), 64'd0);
    repeat (4) step();

    // Forwarding priority: in_* over stage 0 over stage 2
    c = cyc;
    drive(1'b1, 5'd3, 32'hA, 1'b0, 1'b0); expect_wr(c + 3, 5'd3, 32'hA); step();
    idle(); step();
    drive(1'b1, 5'd3, 32'hB, 1'b0, 1'b0); expect_wr(c + 5, 5'd3, 32'hB); step();
    drive(1'b1, 5'd3, 32'hC, 1'b0, 1'b0);
    fwd_a = {5'd0, 5'd3};
    #1;
    chk("fwd_in_hit", 64'(fwd_hit), 64'b01);
    chk("fwd_in_d0", 64'(fwd_d[31:0]), 64'hC);
    chk("fwd_x0_d1", 64'(fwd_d[63:32]), 64'd0);
    in_we = 1'b0;
    #1;
    chk("fwd_s0_d0", 64'(fwd_d[31:0]), 64'hB);
    fwd_a = {5'd17, 5'd3};
    #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 64'b01);
    chk("fwd_miss_d1", 64'(fwd_d[63:32]), 64'd0);
    fwd_a = {5'd3, 5'd17};
    #1;
    chk("fwd_p1_hit", 64'(fwd_hit), 64'b10);
    chk("fwd_p1_d1", 64'(fwd_d[63:32]), 64'hB);
    step(); step();
    chk("fwd_s2_d1", 64'(fwd_d[63:32]), 64'hB);
    fwd_a = '0;
    idle();

    // Drain and confirm every expected write was seen
    for (int i = 0; i < 10; i++) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
